es8psk_rx_ctrl: RTL and testbench

Receive-side sequencer for the ES8PSK preamble correlator and peak detector. It estimates the correlation noise floor and derives the detection threshold from it. It arms and disarms detection by driving that threshold, then supervises each message window by counting symbol strobes. It sits between the correlator output and the peak detector and reports per-message pass/fail to the frame decoder.

---
 rtl/es8psk_rx_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_es8psk_rx_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/es8psk_rx_ctrl.sv
// ES8PSK receive sequencer: noise-floor training, detection threshold arming,
// per-message strobe supervision. Statistics counters enabled by RX_CTRL_STATS_EN.
module es8psk_rx_ctrl #(
  parameter int          WIN_LOG2    = 8,
  parameter int          K_SHIFT     = 3,
  parameter logic [19:0] THRESH_MIN  = 20'd1000,
  parameter int          EXP_STROBES = 234,
  parameter int          STROBE_TOL  = 2,
  parameter int          HOLDOFF     = 64,
  parameter logic [15:0] RETRAIN     = 16'd20000
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        enable,
  input  logic [19:0] corr,
  input  logic        strobe,
  input  logic        ena_message,
  output logic [19:0] thresh,
  output logic        armed,
  output logic        busy,
  output logic [19:0] noise_level,
  output logic [15:0] strobe_cnt,
  output logic        msg_ok,
  output logic        msg_err,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam int AW = 20 + WIN_LOG2;
  localparam int TW = 20 + K_SHIFT;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRAIN   = 3'd1,
    LOAD    = 3'd2,
    ARMED   = 3'd3,
    RECEIVE = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                ena_q;
  logic                ena_qq;
  logic                strobe_q;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_last;
  logic [15:0]         idle_cnt;
  logic [15:0]         hold_cnt;
  logic [19:0]         thr_store;
  logic [19:0]         thr_clamp;
  logic [19:0]         thr_next;
  logic [TW-1:0]       t_wide;
  logic                rise;
  logic                fall;
  logic [15:0]         final_cnt;
  logic                in_range;

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Edge detection, strobe accounting, threshold clamp and next-state logic
  always_comb begin
    rise     = ena_q & ~ena_qq;
    fall     = ~ena_q & ena_qq;
    acc_sum  = acc + AW'(corr);
    win_last = (win_cnt == {WIN_LOG2{1'b1}});
    t_wide   = TW'(noise_level) << K_SHIFT;
    if (t_wide < TW'(THRESH_MIN)) begin
      thr_clamp = THRESH_MIN;
    end else if (t_wide > TW'(20'hFFFFE)) begin
      thr_clamp = 20'hFFFFE;
    end else begin
      thr_clamp = t_wide[19:0];
    end
    if (state == LOAD) begin
      thr_next = thr_clamp;
    end else begin
      thr_next = thr_store;
    end
    if (strobe_q && (strobe_cnt != 16'hFFFF)) begin
      final_cnt = strobe_cnt + 16'd1;
    end else begin
      final_cnt = strobe_cnt;
    end
    in_range = (32'(final_cnt) + 32'(STROBE_TOL) >= 32'(EXP_STROBES)) &&
               (32'(final_cnt) <= 32'(EXP_STROBES) + 32'(STROBE_TOL));

    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = TRAIN;
        TRAIN: begin
          if (win_last) state_next = LOAD;
          else          state_next = TRAIN;
        end
        LOAD:    state_next = ARMED;
        ARMED: begin
          if (rise)                                state_next = RECEIVE;
          else if (idle_cnt == RETRAIN - 16'd1)    state_next = TRAIN;
          else                                     state_next = ARMED;
        end
        RECEIVE: begin
          if (fall) state_next = HOLD;
          else      state_next = RECEIVE;
        end
        HOLD: begin
          if (hold_cnt == 16'(HOLDOFF - 1)) state_next = ARMED;
          else                              state_next = HOLD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ena_q       <= 1'b0;
      ena_qq      <= 1'b0;
      strobe_q    <= 1'b0;
      acc         <= {AW{1'b0}};
      win_cnt     <= {WIN_LOG2{1'b0}};
      idle_cnt    <= 16'd0;
      hold_cnt    <= 16'd0;
      thr_store   <= 20'hFFFFF;
      thresh      <= 20'hFFFFF;
      noise_level <= 20'd0;
      strobe_cnt  <= 16'd0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      msg_ok      <= 1'b0;
      msg_err     <= 1'b0;
    end else begin
      ena_q    <= ena_message;
      ena_qq   <= ena_q;
      strobe_q <= strobe;
      msg_ok   <= 1'b0;
      msg_err  <= 1'b0;
      // Accumulator is held clear outside TRAIN so each window starts fresh
      if (state == TRAIN) begin
        acc     <= acc_sum;
        win_cnt <= win_cnt + {{(WIN_LOG2-1){1'b0}}, 1'b1};
      end else begin
        acc     <= {AW{1'b0}};
        win_cnt <= {WIN_LOG2{1'b0}};
      end
      if ((state == TRAIN) && (state_next == LOAD)) begin
        noise_level <= acc_sum[WIN_LOG2 +: 20];
      end
      if (state == LOAD) begin
        thr_store <= thr_clamp;
      end
      if (state == ARMED) idle_cnt <= idle_cnt + 16'd1;
      else                idle_cnt <= 16'd0;
      if (state == HOLD) hold_cnt <= hold_cnt + 16'd1;
      else               hold_cnt <= 16'd0;
      // The strobe seen alongside the registered rising edge opens the count
      if ((state == ARMED) && (state_next == RECEIVE)) begin
        strobe_cnt <= {15'd0, strobe_q};
      end else if ((state == RECEIVE) && enable) begin
        strobe_cnt <= final_cnt;
      end
      if ((state == RECEIVE) && (state_next == HOLD)) begin
        msg_ok  <= in_range;
        msg_err <= ~in_range;
      end
      if ((state_next == ARMED) || (state_next == RECEIVE)) thresh <= thr_next;
      else                                                 thresh <= 20'hFFFFF;
      armed <= (state_next == ARMED);
      busy  <= (state_next == RECEIVE) || (state_next == HOLD);
    end
  end

`ifdef RX_CTRL_STATS_EN
  // Saturating message statistics
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ok_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else begin
      if (msg_ok && (ok_cnt != 16'hFFFF))   ok_cnt  <= ok_cnt + 16'd1;
      if (msg_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign ok_cnt  = 16'd0;
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_es8psk_rx_ctrl.sv
// Self-checking bench for es8psk_rx_ctrl: randomized training samples and
// strobe patterns compared against an arithmetic reference model.
module tb_es8psk_rx_ctrl;

  logic        clk;
  logic        reset_b;
  logic        enable;
  logic [19:0] corr;
  logic        strobe;
  logic        ena_message;
  logic [19:0] thresh;
  logic        armed;
  logic        busy;
  logic [19:0] noise_level;
  logic [15:0] strobe_cnt;
  logic        msg_ok;
  logic        msg_err;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] exp_thr  = 20'hFFFFF;
  int          ok_model = 0;
  int          err_model = 0;

  es8psk_rx_ctrl dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .corr(corr),
    .strobe(strobe), .ena_message(ena_message), .thresh(thresh),
    .armed(armed), .busy(busy), .noise_level(noise_level),
    .strobe_cnt(strobe_cnt), .msg_ok(msg_ok), .msg_err(msg_err),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_stat(input int model);
`ifdef RX_CTRL_STATS_EN
    return model;
`else
    return 0;
`endif
  endfunction

  task automatic test_reset();
    reset_b = 1'b0; enable = 1'b0; corr = 20'd0; strobe = 1'b0; ena_message = 1'b0;
    #23;
    n_checks++;
    if ({thresh, armed, busy, noise_level, strobe_cnt, msg_ok, msg_err, ok_cnt, err_cnt}
        !== {20'hFFFFF, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_values: thresh=%h armed=%b busy=%b noise=%0d scnt=%0d, want thresh=fffff rest 0",
               thresh, armed, busy, noise_level, strobe_cnt);
    end
    reset_b = 1'b1;
    tick();
  endtask

  // Called in the first TRAIN cycle; leaves the bench in the first ARMED cycle.
  task automatic run_train(input int base, input int spread, input string name);
    longint sum = 0;
    longint nz, t;
    int     v;
    for (int i = 0; i < 256; i++) begin
      v = base + ((spread > 0) ? int'($urandom_range(spread, 0)) : 0);
      if (v > 'hFFFFF) v = 'hFFFFF;
      corr = 20'(v);
      sum += v;
      if (i == 4) begin
        n_checks++;
        if (thresh !== 20'hFFFFF || armed !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_train_disarmed: thresh=%h armed=%b, want fffff 0", name, thresh, armed);
        end
      end
      tick();
    end
    n_checks++;
    if (thresh !== 20'hFFFFF || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_load_cycle: thresh=%h armed=%b, want fffff 0", name, thresh, armed);
    end
    tick();
    nz = sum / 256;
    t  = nz * 8;
    if (t < 1000) t = 1000;
    if (t > 'hFFFFE) t = 'hFFFFE;
    exp_thr = 20'(t);
    n_checks++;
    if (noise_level !== 20'(nz)) begin
      n_fail++;
      $display("FAIL %s_noise: got %0d want %0d", name, noise_level, nz);
    end
    n_checks++;
    if (thresh !== exp_thr || armed !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_thresh: got %0d armed=%b busy=%b want %0d armed=1 busy=0",
               name, thresh, armed, busy, exp_thr);
    end
  endtask

  task automatic test_train(input int base, input int spread, input string name);
    enable = 1'b0; corr = 20'd0;
    tick(); tick();
    n_checks++;
    if (thresh !== 20'hFFFFF || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: thresh=%h armed=%b want fffff 0", name, thresh, armed);
    end
    enable = 1'b1;
    tick();
    run_train(base, spread, name);
  endtask

  // Called in an ARMED cycle with ena_message low for at least one cycle.
  task automatic test_message(input int n_str, input bit coinc, input bit late_high);
    bit pos[1170];
    int placed = 0;
    int idx;
    bit exp_ok;
    for (int i = 0; i < 1170; i++) pos[i] = 1'b0;
    while (placed < (coinc ? n_str - 1 : n_str)) begin
      idx = int'($urandom_range(1169, 1));
      if (!pos[idx]) begin
        pos[idx] = 1'b1;
        placed++;
      end
    end
    exp_ok = (n_str - 234 <= 2) && (234 - n_str <= 2);
    for (int i = 0; i < 1170; i++) begin
      if (i == 1) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL msg_early_busy: busy=%b want 0", busy);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (busy !== 1'b1 || armed !== 1'b0 || thresh !== exp_thr) begin
          n_fail++;
          $display("FAIL msg_receive_entry: busy=%b armed=%b thresh=%0d want 1 0 %0d",
                   busy, armed, thresh, exp_thr);
        end
      end
      ena_message = 1'b1;
      strobe = pos[i];
      tick();
    end
    ena_message = 1'b0;
    strobe = coinc;
    tick();
    n_checks++;
    if (msg_ok !== 1'b0 || msg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL msg_pulse_early: ok=%b err=%b want 0 0", msg_ok, msg_err);
    end
    strobe = 1'b0;
    tick();
    if (exp_ok) ok_model++;
    else        err_model++;
    n_checks++;
    if (msg_ok !== exp_ok || msg_err !== !exp_ok || strobe_cnt !== 16'(n_str)) begin
      n_fail++;
      $display("FAIL msg_result: ok=%b err=%b cnt=%0d want ok=%b err=%b cnt=%0d",
               msg_ok, msg_err, strobe_cnt, exp_ok, !exp_ok, n_str);
    end
    tick();
    n_checks++;
    if (msg_ok !== 1'b0 || msg_err !== 1'b0 || thresh !== 20'hFFFFF) begin
      n_fail++;
      $display("FAIL msg_holdoff: ok=%b err=%b thresh=%h want 0 0 fffff", msg_ok, msg_err, thresh);
    end
    for (int i = 3; i < 65; i++) begin
      if (late_high && i == 10) ena_message = 1'b1;
      tick();
    end
    n_checks++;
    if (busy !== 1'b1 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL msg_holdoff_end: busy=%b armed=%b want 1 0", busy, armed);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || armed !== 1'b1 || thresh !== exp_thr ||
        ok_cnt !== 16'(exp_stat(ok_model)) || err_cnt !== 16'(exp_stat(err_model))) begin
      n_fail++;
      $display("FAIL msg_rearm: busy=%b armed=%b thresh=%0d ok=%0d err=%0d want 0 1 %0d %0d %0d",
               busy, armed, thresh, ok_cnt, err_cnt, exp_thr, exp_stat(ok_model), exp_stat(err_model));
    end
    if (late_high) begin
      repeat (4) tick();
      n_checks++;
      if (busy !== 1'b0 || armed !== 1'b1) begin
        n_fail++;
        $display("FAIL msg_high_on_arm: busy=%b armed=%b want 0 1", busy, armed);
      end
      ena_message = 1'b0;
      tick();
    end
  endtask

  // Called in the first ARMED cycle.
  task automatic test_retrain();
    int k = 0;
    corr = 20'd2000;
    while (k < 20100 && armed === 1'b1) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== 20000) begin
      n_fail++;
      $display("FAIL retrain_timeout: armed for %0d cycles want 20000", k);
    end
    run_train(2000, 0, "retrain");
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 100; i++) begin
      ena_message = 1'b1;
      strobe = (i % 5 == 0) && (i < 95);
      tick();
    end
    strobe = 1'b1;
    enable = 1'b0;
    tick();
    strobe = 1'b0;
    n_checks++;
    if (thresh !== 20'hFFFFF || armed !== 1'b0 || busy !== 1'b0 || strobe_cnt !== 16'd19) begin
      n_fail++;
      $display("FAIL enable_drop: thresh=%h armed=%b busy=%b cnt=%0d want fffff 0 0 19",
               thresh, armed, busy, strobe_cnt);
    end
    ena_message = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (msg_ok !== 1'b0 || msg_err !== 1'b0 || strobe_cnt !== 16'd19) begin
        n_fail++;
        $display("FAIL enable_drop_no_pulse: ok=%b err=%b cnt=%0d want 0 0 19", msg_ok, msg_err, strobe_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    corr = 20'd777;
    repeat (40) tick();
    #2;
    reset_b = 1'b0;
    #1;
    n_checks++;
    if ({thresh, armed, busy, noise_level, strobe_cnt, msg_ok, msg_err, ok_cnt, err_cnt}
        !== {20'hFFFFF, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: thresh=%h noise=%0d cnt=%0d ok=%0d err=%0d want fffff 0 0 0 0",
               thresh, noise_level, strobe_cnt, ok_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_train(500, 0, "c500");
    test_train(100, 0, "c100");
    test_train('hFFFFF, 0, "cmax");
    test_train(int'($urandom_range(60000, 50)), int'($urandom_range(5000, 0)), "rand");
    test_message(234, 1'b0, 1'b0);
    test_message(230, 1'b0, 1'b0);
    test_message(236, 1'b0, 1'b1);
    test_message(232, 1'b1, 1'b0);
    test_message(int'($urandom_range(242, 226)), 1'b1, 1'b0);
    test_message(int'($urandom_range(242, 226)), 1'b0, 1'b0);
    test_retrain();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
